// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier sequencer: operand capture, radix-2 iteration,
// sticky done and WAIT stall for the processor START/WAIT/ST flow.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             wait_req,
  input  logic             res_sel,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] res_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0]   a, b, m;
  logic [2*WIDTH-1:0] p, p_nxt;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   cnt;
  logic               go, last;

  assign go   = start & (state != CALC);
  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = CALC;
      CALC:    if (last)  nstate = DONE;
      DONE:    if (start) nstate = CALC;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == CALC);
    stall   = wait_req & ~done;
    res_out = res_sel ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
  end

  // m holds the multiplicand sampled at start so a same-edge ld_a
  // updates A without disturbing the product in flight.
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
    if (p[0]) p_nxt = {sum, p[WIDTH-1:1]};
    else      p_nxt = {1'b0, p[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      b    <= '0;
      m    <= '0;
      p    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      if (state != CALC) begin
        if (ld_a) a <= din;
        if (ld_b) b <= din;
      end
      if (go) begin
        m   <= a;
        p   <= {{WIDTH{1'b0}}, b};
        cnt <= '0;
      end else if (state == CALC) begin
        p   <= p_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      done <= (state == DONE) & ~start;
    end
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencer and operand/result holding logic for the synchronous unsigned shift-add multiplier driven by the processor's START/WAIT instructions.
- Captures two operands from register-file loads and starts on the START strobe.
- Iterates the radix-2 shift-add datapath for WIDTH cycles.
- Holds the processor in WAIT until the product is valid, then presents the product low/high words for the two ST instructions.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
ld_a  input  1  one-cycle strobe: capture din as operand A.
ld_b  input  1  one-cycle strobe: capture din as operand B.
din  input  WIDTH  operand data from register file.
start  input  1  one-cycle strobe from START instruction.
wait_req  input  1  high while the processor executes WAIT.
res_sel  input  1  0 = low word, 1 = high word on res_out.
busy  output  1  high while iterating.
done  output  1  product valid; sticky.
stall  output  1  processor stall request (wait_req & ~done).
res_out  output  WIDTH  selected product word.

Behaviour:
- Reset (async, rst_n low): state=IDLE, A=B=0, product register P=0, counter=0, busy=0, done=0, stall=0, res_out=0. Reset mid-iteration aborts immediately; no partial result survives.
- States: IDLE, CALC, DONE.
- IDLE: ld_a/ld_b load A/B on the clock edge. start=1 moves to CALC next edge: P <= {WIDTH'b0, B}, counter <= 0, done <= 0, busy <= 1.
- CALC, each cycle:
  - If P[0]=1: upper sum = P[2W-1:W] + A, computed at W+1 bits.
  - P <= {carry, sum, P[W-1:1]}; otherwise plain logical shift right of P with a 0 inserted.
  - counter++.
  - When counter==WIDTH-1 the edge performs the last step and moves to DONE.
- DONE: done=1, busy=0. Stays until the next start, which re-enters CALC and clears done in the same edge. ld_a/ld_b in DONE update A/B only; they do not clear done or P.
- Latency: start sampled at edge 0 sets busy=1 after edge 0. WIDTH iteration edges follow (edges 1..WIDTH). done=1 after edge WIDTH+1. This is WIDTH+1 cycles from the start edge to done.
- Result: P equals A*B exact (2*WIDTH bits, no truncation).
- res_out is combinational from P: res_sel=0 gives P[W-1:0], res_sel=1 gives P[2W-1:W]. It is valid only when done=1; during CALC it shows intermediate P.
- stall = wait_req & ~done (combinational).
  - WAIT issued after done has no stall.
  - WAIT issued in IDLE with done=0 (no prior start) stalls indefinitely; this is the intended software error behaviour.
- Simultaneous events:
  - start while busy (CALC) is ignored.
  - ld_a/ld_b during CALC are ignored; operands are frozen.
  - start and ld_a in the same IDLE cycle: the multiplication uses the old A, and A is then updated.
  - ld_a and ld_b in the same cycle both load din.
- Counter wrap is unreachable; CNT_W covers WIDTH.

Test Plan:
- Reset: assert rst_n=0 mid-CALC with A=3, B=5 -> all outputs 0 immediately, state IDLE; after release, done=0 and res_out=0.
- Basic latency: A=3, B=5, start at edge 0 -> busy=1 for edges 1..32, done=1 after edge 33, low word 0x0000000F, high word 0x00000000; wait_req high from edge 1 gives stall high until done.
- Max operands: A=B=0xFFFFFFFF -> high word 0xFFFFFFFE, low word 0x00000001 (carry path exercised).
- Cross-word: A=B=0x00010000 -> high word 0x00000001, low word 0x00000000. Zero operand: A=0x01234567, B=0 -> both words 0.
- Ignored inputs: start 10 cycles into CALC plus ld_a=1 with din=0x7 -> result unchanged, done exactly once at the original cycle. Back-to-back start in DONE -> done drops next edge and the new product is valid 33 cycles later.
- Stall: wait_req=1 with no prior start -> stall stays 1 for 100 cycles; then issue start -> stall falls the cycle done rises.
